// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the uart_riscv serial blocks:
//                oversampling ratio, line-control bit positions and the
//                receiver state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Ticks of the 16x enable per serial bit
    localparam int OVS = 16;

    // Line-control register bit positions: {stop_bits, parity_type, parity_en}
    localparam int LCR_PEN = 0;   // 1 = parity bit present
    localparam int LCR_EPS = 1;   // 1 = even parity, 0 = odd parity
    localparam int LCR_STB = 2;   // stop-bit count (transmit side only)

    // Receiver state encoding
    localparam int          c_state_w     = 3;
    localparam logic [2:0]  c_st_idle     = 3'd0;
    localparam logic [2:0]  c_st_start    = 3'd1;
    localparam logic [2:0]  c_st_data     = 3'd2;
    localparam logic [2:0]  c_st_parity   = 3'd3;
    localparam logic [2:0]  c_st_stop     = 3'd4;
    localparam logic [2:0]  c_st_break    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Multi-flop synchronizer for a single asynchronous input
//                (RXD, CTS, DSR ...). Resets to RESET_VAL so an idle line
//                looks idle immediately after reset.
//  Ports       : clk   - destination clock
//                rst   - asynchronous active-high reset
//                d     - asynchronous input
//                q     - synchronized output, STAGES clk cycles behind d
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= RESET_VAL;
                end else begin
                    r_sync <= d;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {STAGES{RESET_VAL}};
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], d};
                end
            end
        end
    endgenerate

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Samples the synchronized RXD line at mid-bit
//                using the shared 16x enable, assembles 8-bit LSB-first
//                frames with optional parity, and holds the byte with
//                sticky parity / framing / overrun flags until rx_ack.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                tick_16x          - one-clk enable at 16x the baud rate
//                rxd               - asynchronous serial input (idle high)
//                lcr[2:0]          - {stop_bits, parity_type, parity_en}
//                rx_ack            - read strobe, clears ready and flags
//                dout[7:0]         - last received byte
//                rx_ready          - unread byte held in dout
//                rx_valid          - one-clk pulse per completed frame
//                parity_err        - parity mismatch on held byte
//                frame_err         - stop bit sampled low on held byte
//                overrun           - frame completed while rx_ready high
//                rx_busy           - frame reception in progress
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int OVS         = uart_pkg::OVS,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_16x,
    input  logic       rxd,
    input  logic [2:0] lcr,
    input  logic       rx_ack,
    output logic [7:0] dout,
    output logic       rx_ready,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    import uart_pkg::*;

    localparam logic [3:0] c_tick_mid  = 4'(OVS/2 - 1);
    localparam logic [3:0] c_tick_last = 4'(OVS - 1);

    logic                 w_rxs;
    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic [3:0]           r_tick_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shreg;
    logic [1:0]           r_lcr_q;
    logic                 r_perr;
    logic [7:0]           r_dout;
    logic                 r_rx_ready;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_cnt_clr;
    logic                 w_shift;
    logic                 w_par_sample;
    logic                 w_done;
    logic                 w_par_exp;
    logic                 w_unused_stb;

    // Stop-bit count only matters to the transmitter
    assign w_unused_stb = lcr[LCR_STB];

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (w_rxs)
    );

    assign w_par_exp = r_lcr_q[LCR_EPS] ? (^r_shreg) : ~(^r_shreg);

    // ------------------------------------------------------------------------
    // Next-state and per-tick strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift      = 1'b0;
        w_par_sample = 1'b0;
        w_done       = 1'b0;
        if (tick_16x) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_rxs) begin
                        w_state_next = c_st_start;
                        w_cnt_clr    = 1'b1;
                    end
                end
                c_st_start: begin
                    // Re-check the start bit at its centre; a high line here
                    // was a glitch, not a frame.
                    if (r_tick_cnt == c_tick_mid) begin
                        w_cnt_clr    = 1'b1;
                        w_state_next = w_rxs ? c_st_idle : c_st_data;
                    end
                end
                c_st_data: begin
                    if (r_tick_cnt == c_tick_last) begin
                        w_cnt_clr = 1'b1;
                        w_shift   = 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            w_state_next = r_lcr_q[LCR_PEN] ? c_st_parity : c_st_stop;
                        end
                    end
                end
                c_st_parity: begin
                    if (r_tick_cnt == c_tick_last) begin
                        w_cnt_clr    = 1'b1;
                        w_par_sample = 1'b1;
                        w_state_next = c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (r_tick_cnt == c_tick_last) begin
                        w_cnt_clr    = 1'b1;
                        w_done       = 1'b1;
                        w_state_next = w_rxs ? c_st_idle : c_st_break;
                    end
                end
                c_st_break: begin
                    // Hold here until the line returns high so a long break
                    // produces a single framing-error frame.
                    if (w_rxs) begin
                        w_state_next = c_st_idle;
                    end
                end
                default: begin
                    w_state_next = c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shreg    <= 8'd0;
            r_lcr_q    <= 2'd0;
            r_perr     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (tick_16x) begin
                r_tick_cnt <= w_cnt_clr ? 4'd0 : r_tick_cnt + 4'd1;
            end
            // Frame format is frozen once the start edge is accepted
            if (r_state == c_st_idle) begin
                r_lcr_q <= lcr[1:0];
                r_perr  <= 1'b0;
            end
            if (w_cnt_clr && (r_state == c_st_start)) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift) begin
                r_shreg <= {w_rxs, r_shreg[7:1]};
            end
            if (w_par_sample) begin
                r_perr <= w_rxs ^ w_par_exp;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Receive buffer and status. A completing frame takes priority over a
    // simultaneous rx_ack: the ack clears only the old frame's flags.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= 8'd0;
            r_rx_ready   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_valid <= w_done;
            if (w_done) begin
                r_dout       <= r_shreg;
                r_rx_ready   <= 1'b1;
                r_parity_err <= (r_parity_err & ~rx_ack) | r_perr;
                r_frame_err  <= (r_frame_err & ~rx_ack) | ~w_rxs;
                r_overrun    <= (r_overrun | r_rx_ready) & ~rx_ack;
            end else if (rx_ack) begin
                r_rx_ready   <= 1'b0;
                r_parity_err <= 1'b0;
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign rx_ready   = r_rx_ready;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign rx_busy    = (r_state != c_st_idle);

endmodule
`default_nettype wire
